// File: rtl/zube_bus_pkg.sv
// Shared definitions for the 8-bit data / 16-bit address strobe bus master.
//   - bus width and phase counter width constants
//   - default cycle timing constants and the value returned on a read ack timeout
//   - bus_state_e: master FSM states
//   - bus_req_t: request payload latched at accept
package zube_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam int unsigned DEF_SETUP_CYCLES  = 2;
    localparam int unsigned DEF_STROBE_CYCLES = 4;
    localparam int unsigned DEF_HOLD_CYCLES   = 1;
    localparam int unsigned DEF_ACK_TIMEOUT   = 15;

    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_cycle_master_if.sv
// Request/response handshake plus strobe-bus control signals of bus_cycle_master.
// The shared data_bus is a tri-state net and stays a plain inout on the top module.
//   master modport: consumes requests and bus_dir, drives ready/response/strobes/address
//   slave modport : the opposite view (requester plus addressed slave)
interface bus_cycle_master_if;
    import zube_bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              write_strobe_b;
    logic              read_strobe_b;
    logic [ADDR_W-1:0] address_bus;
    logic              bus_dir;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_dir,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               write_strobe_b, read_strobe_b, address_bus
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_dir,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               write_strobe_b, read_strobe_b, address_bus
    );

endinterface

// File: rtl/bus_cycle_timer.sv
// Loadable 4-bit down counter timing each bus cycle phase.
//   clk, reset_b : clock, synchronous active-low reset
//   load/load_val: reload the counter (takes priority over counting)
//   count        : current counter value (registered)
//   done_c       : count has reached zero; the counter then holds at zero
module bus_cycle_timer
    import zube_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Reload or count down, saturating at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign done_c = (count_q == '0);

endmodule

// File: rtl/bus_cycle_master.sv
// Upstream strobe-bus master: turns valid/ready single transfers into
// SETUP -> STROBE -> HOLD bus cycles and returns read data.
//   clk, reset_b : clock, synchronous active-low reset
//   bus          : bus_cycle_master_if.master (request, response, strobes, address, bus_dir)
//   data_bus     : shared 8-bit data, driven only from SETUP through HOLD of a write
// Build option BUS_CYCLE_ACK_EN: read strobes stretch until bus_dir is seen (after the
// minimum strobe length) or ACK_TIMEOUT strobe cycles elapse (then rdata 8'hFF, rsp_err 1).
module bus_cycle_master
    import zube_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_b,
    bus_cycle_master_if.master bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              wr_stb_b_q, wr_stb_b_d;
    logic              rd_stb_b_q, rd_stb_b_d;
    logic [ADDR_W-1:0] addr_bus_q, addr_bus_d;
    logic              data_oe_q, data_oe_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_done_c;

    logic              accept_c;
    logic              strobe_end_c;
    logic              timeout_c;
    logic [CNT_W-1:0]  strobe_load_c;
    logic              hold_last_c;

    bus_cycle_timer u_timer (
        .clk      (clk),
        .reset_b  (reset_b),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done_c   (tmr_done_c)
    );

    assign accept_c = bus.req_valid && req_ready_q;

`ifdef BUS_CYCLE_ACK_EN
    // Read strobes run on the timeout budget; the counter value tells how long the
    // strobe has been low, so the ack is honoured only once the minimum has elapsed.
    localparam logic [CNT_W-1:0] ACK_MIN_CNT = CNT_W'(ACK_TIMEOUT - STROBE_CYCLES);
    logic ack_c;
    assign ack_c         = !req_q.write && bus.bus_dir && (tmr_count <= ACK_MIN_CNT);
    assign strobe_end_c  = ack_c || tmr_done_c;
    assign timeout_c     = !req_q.write && tmr_done_c && !ack_c;
    assign strobe_load_c = req_q.write ? CNT_W'(STROBE_CYCLES - 1) : CNT_W'(ACK_TIMEOUT - 1);
`else
    localparam int unsigned UNUSED_ACK_TIMEOUT = ACK_TIMEOUT;
    logic unused_bus_dir;
    assign unused_bus_dir = bus.bus_dir;
    assign strobe_end_c   = tmr_done_c;
    assign timeout_c      = 1'b0;
    assign strobe_load_c  = CNT_W'(STROBE_CYCLES - 1);
`endif

    // Next state, request latch, read capture; outputs derive from the next state so
    // every bus pin comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    req_d.write = bus.req_write;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    state_d     = SETUP;
                    tmr_load    = 1'b1;
                    tmr_val     = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (tmr_done_c) begin
                    state_d  = STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = strobe_load_c;
                end
            end
            STROBE: begin
                if (strobe_end_c) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYCLES - 1);
                    if (req_q.write) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else if (timeout_c) begin
                        rsp_rdata_d = TIMEOUT_RDATA;
                        rsp_err_d   = 1'b1;
                    end else begin
                        rsp_rdata_d = data_bus;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (tmr_done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Last HOLD cycle: either entering HOLD with a one-cycle hold, or one count left.
        hold_last_c = (state_d == HOLD) &&
                      ((state_q != HOLD) ? (HOLD_CYCLES == 1) : (tmr_count == CNT_W'(1)));

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = hold_last_c;
        addr_bus_d  = (state_d == IDLE) ? '0 : req_d.addr;
        wr_stb_b_d  = !((state_d == STROBE) && req_d.write);
        rd_stb_b_d  = !((state_d == STROBE) && !req_d.write);
        data_oe_d   = (state_d != IDLE) && req_d.write;
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_stb_b_q  <= 1'b1;
            rd_stb_b_q  <= 1'b1;
            addr_bus_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wr_stb_b_q  <= wr_stb_b_d;
            rd_stb_b_q  <= rd_stb_b_d;
            addr_bus_q  <= addr_bus_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.write_strobe_b = wr_stb_b_q;
    assign bus.read_strobe_b  = rd_stb_b_q;
    assign bus.address_bus    = addr_bus_q;

    assign data_bus = data_oe_q ? req_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_cycle_master.sv
// Bench for bus_cycle_master with a two-register slave at 16'hA000/16'hA001.
// A transaction-level model predicts every output per cycle from accept time and
// phase lengths; directed scenarios add hand-computed literal expectations.
module tb_bus_cycle_master;

    localparam int S_CYC  = 2;
    localparam int ST_CYC = 4;
    localparam int H_CYC  = 1;
    localparam int TO_CYC = 15;

    logic clk = 1'b0;
    logic reset_b;
    wire [7:0] data_bus;

    bus_cycle_master_if bus ();

    bus_cycle_master dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .bus      (bus.master),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;

    // Two-register slave: drives data while its read strobe is low, captures on write strobe.
    logic [7:0] slv_reg [0:1];
    logic       slv_hit;
    logic       slv_oe;
    logic       bus_dir_q;
    assign slv_hit     = (bus.address_bus[15:1] == 15'h5000);
    assign slv_oe      = slv_hit && !bus.read_strobe_b;
    assign data_bus    = slv_oe ? slv_reg[bus.address_bus[0]] : 8'hzz;
    assign bus.bus_dir = bus_dir_q;
    always @(posedge clk) begin
        if (slv_hit && !bus.write_strobe_b) slv_reg[bus.address_bus[0]] <= data_bus;
        bus_dir_q <= slv_oe;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Transaction model state
    bit         m_valid  = 0;
    bit         m_active = 0;
    bit         m_ready  = 0;
    int         m_acc    = 0;
    bit         m_write;
    logic [15:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    bit         m_err;
    bit         m_chk_rd;
    int         m_slen;
    int         m_total;
    logic [7:0] m_mem [0:1];
    bit         m_acc_now;
    bit         m_hit;

    // DUT event logs (pre-edge values, indexed by edge number)
    int acc_log[$];
    int rsp_log[$];
    int wr_run = 0, wr_len = 0, rd_run = 0, rd_len = 0;

    always @(posedge clk) begin
        cyc++;
        if (bus.req_valid && bus.req_ready) acc_log.push_back(cyc);
        if (bus.rsp_valid) rsp_log.push_back(cyc);
        if (!bus.write_strobe_b) wr_run++;
        else if (wr_run != 0) begin wr_len = wr_run; wr_run = 0; end
        if (!bus.read_strobe_b) rd_run++;
        else if (rd_run != 0) begin rd_len = rd_run; rd_run = 0; end

        m_acc_now = reset_b && bus.req_valid && m_ready;
        if (!reset_b) begin
            m_valid  = 1;
            m_active = 0;
            m_ready  = 0;
        end else begin
            if (m_active && (cyc - m_acc) == m_total) m_active = 0;
            if (m_acc_now) begin
                m_active = 1;
                m_acc    = cyc;
                m_write  = bus.req_write;
                m_addr   = bus.req_addr;
                m_wdata  = bus.req_wdata;
                m_hit    = (bus.req_addr == 16'hA000) || (bus.req_addr == 16'hA001);
                m_slen   = ST_CYC;
                m_err    = 0;
                m_chk_rd = 1;
                if (m_write) begin
                    m_rdata = 8'h00;
                    if (m_hit) m_mem[m_addr[0]] = m_wdata;
                end else if (m_hit) begin
                    m_rdata = m_mem[m_addr[0]];
                end else begin
`ifdef BUS_CYCLE_ACK_EN
                    m_slen  = TO_CYC;
                    m_rdata = 8'hFF;
                    m_err   = 1;
`else
                    m_rdata  = 8'h00;
                    m_chk_rd = 0;
`endif
                end
                m_total = S_CYC + m_slen + H_CYC;
            end
            m_ready = !m_active;
        end
    end

    // Per-cycle comparison against the model
    int k;
    bit e_stb, e_rv, e_oe;
    always @(negedge clk) begin
        if (m_valid) begin
            k     = cyc - m_acc;
            e_stb = m_active && (k >= S_CYC) && (k < S_CYC + m_slen);
            e_rv  = m_active && (k == m_total - 1);
            e_oe  = m_active && m_write;
            check("req_ready", 32'(bus.req_ready), 32'(m_ready));
            check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
            check("write_strobe_b", 32'(bus.write_strobe_b), 32'(!(e_stb && m_write)));
            check("read_strobe_b", 32'(bus.read_strobe_b), 32'(!(e_stb && !m_write)));
            check("address_bus", 32'(bus.address_bus), m_active ? 32'(m_addr) : 32'h0);
            check("data_drive", 32'(dut.data_oe_q), 32'(e_oe));
            if (e_oe) check("data_bus", 32'(data_bus), 32'(m_wdata));
            if (e_rv) begin
                check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
                if (m_chk_rd) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
            end
        end
    end

    task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er);
        int n;
        rd = 8'h00;
        er = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fail_now("xfer_accept"); bus.req_valid = 1'b0; return; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin fail_now("xfer_response"); return; end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0] rd;
    logic       er;
    int         n;

    initial begin
        reset_b       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.req_ready), 32'h0);
        check("reset_wstb", 32'(bus.write_strobe_b), 32'h1);
        check("reset_rstb", 32'(bus.read_strobe_b), 32'h1);
        check("reset_addr", 32'(bus.address_bus), 32'h0);
        check("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'h0);
        reset_b = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(bus.req_ready), 32'h1);

        // Write then read back A000
        xfer(1'b1, 16'hA000, 8'h5A, rd, er);
        check("wr_rdata_zero", 32'(rd), 32'h00);
        xfer(1'b0, 16'hA000, 8'h00, rd, er);
        check("rd_a000", 32'(rd), 32'h5A);
        check("rd_a000_err", 32'(er), 32'h0);
        @(negedge clk);
        check("wr_strobe_len", 32'(wr_len), 32'd4);
        check("rd_strobe_len", 32'(rd_len), 32'd4);

        // No cross-write between the two registers
        xfer(1'b1, 16'hA001, 8'hC3, rd, er);
        xfer(1'b0, 16'hA000, 8'h00, rd, er);
        check("rd_a000_again", 32'(rd), 32'h5A);
        xfer(1'b0, 16'hA001, 8'h00, rd, er);
        check("rd_a001", 32'(rd), 32'hC3);

        // Three requests with req_valid held high
        repeat (2) @(negedge clk);
        acc_log.delete();
        rsp_log.delete();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1; bus.req_addr = 16'hA000; bus.req_wdata = 8'h11;
        n = 0;
        for (int idx = 0; idx < 3 && n < 100; n++) begin
            if (bus.req_ready) begin
                idx++;
                @(negedge clk);
                if (idx == 1) begin bus.req_write = 1'b1; bus.req_addr = 16'hA001; bus.req_wdata = 8'h22; end
                else if (idx == 2) begin bus.req_write = 1'b0; bus.req_addr = 16'hA001; bus.req_wdata = 8'h00; end
                else bus.req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        n = 0;
        while (rsp_log.size() < 3 && n < 60) begin @(negedge clk); n++; end
        if (acc_log.size() != 3 || rsp_log.size() != 3) begin
            fail_now("b2b_events");
        end else begin
            check("b2b_spacing_1", 32'(acc_log[1] - acc_log[0]), 32'd8);
            check("b2b_spacing_2", 32'(acc_log[2] - acc_log[1]), 32'd8);
            for (int i = 0; i < 3; i++) check("b2b_latency", 32'(rsp_log[i] - acc_log[i]), 32'd7);
        end

        // Reset during the second write strobe cycle
        rsp_log.delete();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'hA001; bus.req_wdata = 8'h77;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.write_strobe_b && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) fail_now("abort_strobe_wait");
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        check("abort_wstb", 32'(bus.write_strobe_b), 32'h1);
        check("abort_rstb", 32'(bus.read_strobe_b), 32'h1);
        check("abort_data_release", 32'(dut.data_oe_q), 32'h0);
        check("abort_ready_in_reset", 32'(bus.req_ready), 32'h0);
        reset_b = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 32'(bus.req_ready), 32'h1);
        repeat (10) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_log.size()), 32'd0);
        xfer(1'b0, 16'hA001, 8'h00, rd, er);

        // Read with no slave present
        xfer(1'b0, 16'h1234, 8'h00, rd, er);
        @(negedge clk);
`ifdef BUS_CYCLE_ACK_EN
        check("noslave_strobe_len", 32'(rd_len), 32'd15);
        check("noslave_err", 32'(er), 32'h1);
        check("noslave_rdata", 32'(rd), 32'hFF);
`else
        check("noslave_strobe_len", 32'(rd_len), 32'd4);
        check("noslave_err", 32'(er), 32'h0);
`endif
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
